uptime_uart_fmt: RTL
====================

Name: uptime_uart_fmt

Overview:
Downstream consumer of the BCD uptime counter. On a start pulse it snapshots the packed BCD digit vector and emits it as an ASCII line: digits MSB-first, then CR and LF. Bytes leave over a valid/ready byte stream into the UART transmitter. Optional leading-zero suppression keeps printed lines short.

Parameters:
P_DIGITS, 3, number of BCD digits on the digits input (4 bits each); must be >= 1.
P_SUPPRESS_ZEROS, 0, 1 = skip leading '0' characters; the least-significant digit is always sent.

Ports:
clk  input  1  clock, active positive edge
rst  input  1  reset, asynchronous, active-high
start  input  1  single-cycle request to print the current digits
digits  input  4*P_DIGITS  packed BCD uptime; digit 0 in bits [3:0]
tx_data  output  8  ASCII byte to UART transmitter
tx_valid  output  1  tx_data is valid
tx_ready  input  1  UART transmitter accepts byte
busy  output  1  a line is being emitted
overrun  output  1  one-cycle pulse when start is dropped

Behaviour:
- Reset (async, rst=1): tx_valid=0, tx_data=8'h00, busy=0, overrun=0, state IDLE, snapshot cleared. On reset release, the block waits for start. Asserting reset mid-line aborts the line; no partial line resumes after reset.
- States: IDLE, DIGIT, CR, LF.
- IDLE:
  - start=1 at edge N captures digits into the snapshot.
  - The digit index loads to P_DIGITS-1.
  - busy=1 and tx_valid=1 from cycle N+1. Latency from start to first valid byte is 1 cycle.
  - If P_SUPPRESS_ZEROS=1, the index at capture skips all leading zero digits above digit 0. The skip is computed combinationally from the snapshot source, so there are no extra cycles.
- DIGIT:
  - tx_data = 8'h30 + snapshot digit[index].
  - A digit > 9 (invalid BCD) is sent as 8'h3F ('?').
  - On handshake (tx_valid & tx_ready): if index==0 go to CR, else decrement index.
- CR: tx_data=8'h0D. On handshake go to LF.
- LF: tx_data=8'h0A. On handshake go to IDLE, with busy=0 and tx_valid=0 from the next cycle.
- Handshake rules:
  - While tx_valid=1 and tx_ready=0, tx_data and tx_valid hold stable.
  - tx_valid never drops without a handshake, except on reset.
  - tx_ready is ignored while tx_valid=0.
  - Back-to-back handshakes are allowed: one byte per cycle when tx_ready is held high.
- The snapshot is immune to digits changing after capture. Digits ticking mid-line does not alter the line.
- Start outside IDLE (including the cycle of the final LF handshake) is dropped and pulses overrun=1 for one cycle. Start in IDLE pulses no overrun.
- Line length is P_DIGITS+2 bytes without suppression. With suppression it is (significant digits, minimum 1) + 2 bytes.
- All outputs are registered. No combinational path runs from tx_ready to tx_valid or tx_data.

Test Plan:
1. P_DIGITS=3, suppress=0, digits=12'h042, start, tx_ready=1 -> bytes 0x30,0x34,0x32,0x0D,0x0A on consecutive cycles. First valid is 1 cycle after start. busy falls the cycle after LF.
2. Same setup with suppress=1 and digits=12'h007 -> bytes 0x37,0x0D,0x0A. With digits=12'h000 -> bytes 0x30,0x0D,0x0A.
3. Backpressure: digits=12'h123, tx_ready toggled 0/1 every cycle plus a 5-cycle stall on the CR byte -> tx_data is stable during every stall. Sequence 0x31,0x32,0x33,0x0D,0x0A is complete with no duplicates.
4. digits changes 12'h199->12'h200 one cycle after start -> the line still prints "199". A start during busy, and a start on the LF handshake cycle, are each ignored with a one-cycle overrun pulse. The line is unaffected.
5. Invalid BCD digits=12'h1A5 -> bytes 0x31,0x3F,0x35,0x0D,0x0A.
6. rst asserted asynchronously (between edges) while the second digit is stalled -> tx_valid=0 and busy=0 immediately. After release with no start, there is no output. A new start prints a full fresh line.

Source files
------------

// File: rtl/uptime_uart_fmt_if.sv
// Byte stream from the uptime formatter into the UART transmitter.
// The master drives data/valid; the slave answers with ready.
interface uptime_uart_fmt_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/uptime_uart_fmt.sv
// Prints a snapshot of the packed BCD uptime as an ASCII line (digits MSB-first, CR, LF)
// over a valid/ready byte stream.
//
// state   | meaning
// IDLE    | waiting for start, nothing offered
// DIGIT   | offering ASCII of snapshot digit[idx]
// CR      | offering carriage return
// LF      | offering line feed, last byte of the line
module uptime_uart_fmt #(
    parameter int P_DIGITS         = 3,
    parameter int P_SUPPRESS_ZEROS = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [4*P_DIGITS-1:0] digits,
    uptime_uart_fmt_if.master     tx,
    output logic                  busy,
    output logic                  overrun
);
    localparam int IDX_W = (P_DIGITS > 1) ? $clog2(P_DIGITS) : 1;

    typedef enum logic [1:0] {S_IDLE, S_DIGIT, S_CR, S_LF} state_t;

    state_t                state_q, state_d;
    logic [IDX_W-1:0]      idx_q, idx_d, first_idx;
    logic [4*P_DIGITS-1:0] snap_q, snap_d;
    logic [7:0]            data_q, data_d;
    logic                  valid_q, valid_d;
    logic                  busy_q, busy_d;
    logic                  ovr_q, ovr_d;
    logic                  hs;

    function automatic logic [7:0] ascii_of(input state_t s, input logic [IDX_W-1:0] i,
                                            input logic [4*P_DIGITS-1:0] v);
        logic [3:0] d;
        d = v[4*i +: 4];
        case (s)
            S_DIGIT: ascii_of = (d > 4'd9) ? 8'h3F : (8'h30 + {4'h0, d});
            S_CR:    ascii_of = 8'h0D;
            S_LF:    ascii_of = 8'h0A;
            default: ascii_of = 8'h00;
        endcase
    endfunction

    // Starting index: highest non-zero digit when suppressing, digit 0 always printed.
    always_comb begin
        first_idx = IDX_W'(P_DIGITS - 1);
        if (P_SUPPRESS_ZEROS != 0) begin
            first_idx = '0;
            for (int i = 1; i < P_DIGITS; i++) begin
                if (digits[4*i +: 4] != 4'd0) first_idx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        snap_d  = snap_q;
        ovr_d   = 1'b0;
        hs      = valid_q & tx.tx_ready;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    snap_d  = digits;
                    idx_d   = first_idx;
                    state_d = S_DIGIT;
                end
            end
            S_DIGIT: begin
                if (hs) begin
                    if (idx_q == '0) state_d = S_CR;
                    else             idx_d   = idx_q - 1'b1;
                end
            end
            S_CR:    if (hs) state_d = S_LF;
            S_LF:    if (hs) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (start && (state_q != S_IDLE)) ovr_d = 1'b1;
        // Outputs are registered, so they are derived from the next state.
        valid_d = (state_d != S_IDLE);
        busy_d  = (state_d != S_IDLE);
        data_d  = ascii_of(state_d, idx_d, snap_d);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            snap_q  <= '0;
            data_q  <= 8'h00;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            snap_q  <= snap_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            ovr_q   <= ovr_d;
        end
    end

    assign tx.tx_data  = data_q;
    assign tx.tx_valid = valid_q;
    assign busy        = busy_q;
    assign overrun     = ovr_q;
endmodule
